muldiv_seq: RTL and testbench

Multi-cycle sequencer for the RV32M operations (funct3 000-111), so the core does not need a combinational 32x32 multiplier or divider.
- Accepts one request at a time over a valid/ready handshake.
- Runs an iterative shift-add multiply or restoring divide on magnitudes, applies sign fix-up, and holds the result until consumed.
- Sits beside the ALU in execute; the pipeline stalls on in_ready/out_valid.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_step.sv | 43 ++++
 rtl/muldiv_seq.sv | 153 +++++++++++++++
 tb/tb_muldiv_seq.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer.
// Holds the funct3 operation codes, the FSM state encoding, the iteration
// count and counter width, plus small decode helpers used at accept time.
package muldiv_pkg;

  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // rs1 is interpreted as signed for these operations
  function automatic logic op_signed_a(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is interpreted as signed for these operations
  function automatic logic op_signed_b(input op_e op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_is_div(input op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the sequencer.
//   in_valid/in_ready   : request handshake, in_op (funct3), in_a (rs1), in_b (rs2)
//   out_valid/out_ready : result handshake, out_result
// master = execute stage (requester), slave = sequencer.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle multiply/divide datapath (combinational).
//   i_acc     : 64-bit accumulator ({hi, lo})
//   i_operand : multiplicand magnitude (multiply)
//   i_divisor : divisor magnitude (divide)
//   i_is_div  : 1 = restoring divide step, 0 = shift-add multiply step
//   o_acc     : accumulator after the step
// Multiply: lo holds the remaining multiplier bits; hi accumulates the
// partial product and the pair shifts right, so after XLEN steps acc is the
// full product. Divide: acc = {rem, quot}; shift left, subtract the divisor
// from rem when it fits and shift a 1 into the quotient.
module muldiv_step #(
  parameter int unsigned XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [XLEN-1:0]   i_operand,
  input  logic [XLEN-1:0]   i_divisor,
  input  logic              i_is_div,
  output logic [2*XLEN-1:0] o_acc
);

  logic [XLEN:0]   w_sum;
  logic [2*XLEN:0] w_sh;
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*XLEN-1:XLEN]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    w_sh     = {i_acc, 1'b0};
    // shifted remainder needs one extra bit before the compare
    w_rem_sh = w_sh[2*XLEN:XLEN];
    w_diff   = w_rem_sh[XLEN-1:0] - i_divisor;
    if (i_is_div) begin
      if (w_rem_sh >= {1'b0, i_divisor}) begin
        o_acc = {w_diff, w_sh[XLEN-1:1], 1'b1};
      end else begin
        o_acc = w_sh[2*XLEN-1:0];
      end
    end else begin
      o_acc = {w_sum, i_acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer.
//   clk   : core clock, rising edge
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort of any operation in progress
//   bus   : muldiv_if slave (request in_*, result out_*)
// Operands are converted to magnitudes at accept, the iterative step runs for
// ITER cycles, the sign is fixed up in FIX, and the result is held in DONE
// until consumed. Divide-by-zero and signed overflow finish directly at accept.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic     clk,
  input logic     rst_n,
  input logic     flush,
  muldiv_if.slave bus
);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  op_e               r_op;
  logic              r_sign_a, r_sign_b;
  logic [XLEN-1:0]   r_mag_a, r_mag_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  op_e               w_in_op;
  logic              w_in_sa, w_in_sb;
  logic [XLEN-1:0]   w_in_mag_a, w_in_mag_b;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_acc_step;
  logic              w_mul_neg;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quot_fix, w_rem_fix;
  logic [XLEN-1:0]   w_fix_res;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Request decode: signedness, magnitudes and the early-exit cases
  always_comb begin
    w_in_op       = op_e'(bus.in_op);
    w_in_sa       = op_signed_a(w_in_op) & bus.in_a[XLEN-1];
    w_in_sb       = op_signed_b(w_in_op) & bus.in_b[XLEN-1];
    w_in_mag_a    = w_in_sa ? -bus.in_a : bus.in_a;
    w_in_mag_b    = w_in_sb ? -bus.in_b : bus.in_b;
    w_special     = 1'b0;
    w_special_res = '0;
    if (op_is_div(w_in_op)) begin
      if (bus.in_b == '0) begin
        w_special     = 1'b1;
        w_special_res = (w_in_op inside {OP_REM, OP_REMU}) ? bus.in_a : '1;
      end else if ((w_in_op inside {OP_DIV, OP_REM}) &&
                   (bus.in_a == MIN_NEG) && (bus.in_b == '1)) begin
        w_special     = 1'b1;
        w_special_res = (w_in_op == OP_DIV) ? MIN_NEG : '0;
      end
    end
  end

  // Next state and handshake outputs; flush overrides everything
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
    if (flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = w_special ? DONE : CALC;
          end
        end
        CALC: if (r_cnt == CNT_W'(ITER - 1)) w_state_nxt = FIX;
        FIX:  w_state_nxt = DONE;
        DONE: if (bus.out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign bus.out_result = r_result;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_mag_a),
    .i_divisor (r_mag_b),
    .i_is_div  (op_is_div(r_op)),
    .o_acc     (w_acc_step)
  );

  // Sign fix-up: the high product half comes from the negated 64-bit value
  always_comb begin
    w_mul_neg  = (r_op == OP_MULHSU) ? r_sign_a : (r_sign_a ^ r_sign_b);
    w_prod_fix = w_mul_neg ? -r_acc : r_acc;
    w_quot_fix = (r_sign_a ^ r_sign_b) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    w_rem_fix  = r_sign_a ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:                       w_fix_res = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_fix_res = w_quot_fix;
      default:                      w_fix_res = w_rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= OP_MUL;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_mag_a  <= '0;
      r_mag_b  <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_op     <= w_in_op;
      r_sign_a <= w_in_sa;
      r_sign_b <= w_in_sb;
      r_mag_a  <= w_in_mag_a;
      r_mag_b  <= w_in_mag_b;
      r_cnt    <= '0;
      // multiply seeds lo with the multiplier, divide seeds quot with the dividend
      r_acc    <= {{XLEN{1'b0}}, op_is_div(w_in_op) ? w_in_mag_a : w_in_mag_b};
      if (w_special) r_result <= w_special_res;
    end else begin
      case (r_state)
        CALC: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX:     r_result <= w_fix_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  muldiv_if #(.XLEN(32)) bus ();

  muldiv_seq #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called #1 after a rising edge. Returns latency counted from the accept edge (=1).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!bus.in_ready) check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    // operands must have been captured at accept
    bus.in_op    = ~op;
    bus.in_a     = 32'hDEADBEEF;
    bus.in_b     = 32'h0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = bus.out_result;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] res;
    int          seen;

    bus.in_valid  = 1'b0;
    bus.in_op     = 3'b000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    add("MUL",    OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    add("MULHU",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    add("MULH",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34);
    add("MULHSU", OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 34);
    add("DIV",    OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    add("REM",    OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    add("DIVU",   OP_DIVU,   32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 34);
    add("REMU",   OP_REMU,   32'hFFFFFFF9, 32'd2,        32'h00000001, 34);
    add("DIVU0",  OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1);
    add("REM0",   OP_REM,    32'h80000000, 32'd0,        32'h80000000, 1);
    add("DIVOVF", OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    add("REMOVF", OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    add("MULHU2", OP_MULHU,  32'h80000000, 32'd4,        32'h00000002, 34);
    add("DIV2",   OP_DIV,    32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 34);

    // reset values
    #1;
    check("rst_in_ready",   32'(bus.in_ready),  32'd1);
    check("rst_out_valid",  32'(bus.out_valid), 32'd0);
    check("rst_out_result", bus.out_result,     32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // directed vectors
    foreach (vecs[i]) begin
      bus.out_ready = 1'b1;
      issue(vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
      check(vecs[i].name, res, vecs[i].exp);
      check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
      @(posedge clk); #1;
      check({vecs[i].name, "_idle"}, 32'(bus.in_ready), 32'd1);
    end

    // backpressure: result held, no new accept until handshake
    bus.out_ready = 1'b0;
    issue(OP_MUL, 32'd6, 32'd7, lat, res);
    check("bp_result", res, 32'd42);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_op    = OP_MUL;
      bus.in_a     = 32'd2;
      bus.in_b     = 32'd3;
      @(posedge clk); #1;
      check("bp_hold_result", bus.out_result,     32'd42);
      check("bp_in_ready",    32'(bus.in_ready),  32'd0);
      check("bp_out_valid",   32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_after_hs_ready", 32'(bus.in_ready),  32'd1);
    check("bp_after_hs_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_new_accepted", 32'(bus.in_ready), 32'd0);
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_new_result", bus.out_result, 32'd6);
    @(posedge clk); #1;

    // flush at counter 10 with a competing request
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    bus.in_a     = 32'd9;
    bus.in_b     = 32'd9;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("fl_busy", 32'(bus.in_ready), 32'd0);
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MUL;
    bus.in_a     = 32'd5;
    bus.in_b     = 32'd5;
    @(posedge clk); #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_in_ready",  32'(bus.in_ready),  32'd1);
    check("fl_out_valid", 32'(bus.out_valid), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.out_valid || !bus.in_ready) seen = 1;
    end
    check("fl_no_result", 32'(seen), 32'd0);
    issue(OP_MUL, 32'd3, 32'd4, lat, res);
    check("fl_mul_result", res, 32'd12);
    check("fl_mul_lat", 32'(lat), 32'd34);
    @(posedge clk); #1;

    // asynchronous reset mid-CALC
    bus.in_valid = 1'b1;
    bus.in_op    = OP_DIVU;
    bus.in_a     = 32'd1000;
    bus.in_b     = 32'd3;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    check("rs_busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rs_in_ready",   32'(bus.in_ready),  32'd1);
    check("rs_out_valid",  32'(bus.out_valid), 32'd0);
    check("rs_out_result", bus.out_result,     32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rs_no_result", 32'(bus.out_valid), 32'd0);
    issue(OP_DIVU, 32'd100, 32'd7, lat, res);
    check("rs_divu_result", res, 32'd14);
    check("rs_divu_lat", 32'(lat), 32'd34);
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
